// File: rtl/pid_cfg_spi_master_if.sv
// Request/status and SPI pin bundle for pid_cfg_spi_master.
// master = requesting side; slave = the SPI engine that drives the pins.
interface pid_cfg_spi_master_if #(
    parameter int NBYTES = 4
);
    logic                  start;
    logic                  abort;
    logic [8*NBYTES-1:0]   data;
    logic                  busy;
    logic                  done;
    logic                  cfg_sck;
    logic                  cfg_mosi;
    logic                  cfg_cs;

    modport master (
        output start, abort, data,
        input  busy, done, cfg_sck, cfg_mosi, cfg_cs
    );

    modport slave (
        input  start, abort, data,
        output busy, done, cfg_sck, cfg_mosi, cfg_cs
    );
endinterface

// File: rtl/pid_cfg_spi_master.sv
// Mode-0 SPI master loading the PID controller config word MSB first, byte NBYTES-1 first.
// CFG_CHECKSUM_EN appends an XOR-of-payload byte to each frame.
module pid_cfg_spi_master #(
    parameter int NBYTES   = 4,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2
) (
    input  logic                clk,
    input  logic                reset,
    pid_cfg_spi_master_if.slave bus
);

`ifdef CFG_CHECKSUM_EN
    localparam int NBITS = 8*NBYTES + 8;
`else
    localparam int NBITS = 8*NBYTES;
`endif
    localparam int MAXC = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(NBITS + 1);

    localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SET_LD   = CW'(CS_SETUP - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_SHIFT_LO = 3'd2;
    localparam logic [2:0] S_SHIFT_HI = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    logic [2:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [BW-1:0]       r_bit;
    logic [NBITS-1:0]    r_shift;
    logic                r_cs;
    logic                r_sck;
    logic                r_mosi;
    logic                r_aborted;

    logic [8*NBYTES-1:0] w_data;
    logic [NBITS-1:0]    w_payload;
    logic                w_in_frame;
    logic                w_load;
    logic                w_abort;

    assign w_data = bus.data;

`ifdef CFG_CHECKSUM_EN
    logic [7:0] w_csum;
    always_comb begin
        w_csum = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            w_csum = w_csum ^ w_data[8*i +: 8];
        end
    end
    assign w_payload = {w_data, w_csum};
`else
    assign w_payload = w_data;
`endif

    assign w_in_frame = (r_state == S_SETUP) || (r_state == S_SHIFT_LO) ||
                        (r_state == S_SHIFT_HI) || (r_state == S_HOLD);

    // A request seen in the final gap cycle starts the next frame directly,
    // so a held start gives frames spaced by exactly CS_SETUP cs-high cycles.
    assign w_load  = bus.start && ((r_state == S_IDLE) ||
                                   ((r_state == S_GAP) && (r_cnt == '0)));
    assign w_abort = bus.abort && w_in_frame;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_aborted <= 1'b0;
        end else if (w_load) begin
            r_state   <= S_SETUP;
            r_cnt     <= SET_LD;
            r_bit     <= '0;
            r_shift   <= w_payload;
            r_cs      <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= w_payload[NBITS-1];
            r_aborted <= 1'b0;
        end else if (w_abort) begin
            r_state   <= S_GAP;
            r_cnt     <= SET_LD;
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_aborted <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_SHIFT_LO;
                        r_cnt   <= DIV_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SHIFT_LO: begin
                    if (r_cnt == '0) begin
                        r_state <= S_SHIFT_HI;
                        r_cnt   <= DIV_LD;
                        r_sck   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SHIFT_HI: begin
                    if (r_cnt == '0) begin
                        r_sck <= 1'b0;
                        if (r_bit == LAST_BIT) begin
                            r_state <= S_HOLD;
                            r_cnt   <= SET_LD;
                        end else begin
                            // falling edge: present the next bit
                            r_state <= S_SHIFT_LO;
                            r_cnt   <= DIV_LD;
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift << 1;
                            r_mosi  <= r_shift[NBITS-2];
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= S_GAP;
                        r_cnt   <= SET_LD;
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_GAP) && (r_cnt == '0) && !r_aborted;
    assign bus.cfg_cs   = r_cs;
    assign bus.cfg_sck  = r_sck;
    assign bus.cfg_mosi = r_mosi;

endmodule

// File: tb/tb_pid_cfg_spi_master.sv
// Directed bench for pid_cfg_spi_master: default instance plus a 1-byte, divide-by-1 instance.
// Expectations follow CFG_CHECKSUM_EN when it is defined for the build.
module tb_pid_cfg_spi_master;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pid_cfg_spi_master_if #(.NBYTES(4)) ifa();
    pid_cfg_spi_master_if #(.NBYTES(1)) ifs();

    pid_cfg_spi_master #(.NBYTES(4), .CLK_DIV(2), .CS_SETUP(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    pid_cfg_spi_master #(.NBYTES(1), .CLK_DIV(1), .CS_SETUP(1)) u_dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs)
    );

`ifdef CFG_CHECKSUM_EN
    localparam logic [63:0] EXP_A53C = 64'hA5_3C0F_F066;
    localparam logic [63:0] EXP_1122 = 64'h11_2233_4444;
    localparam logic [63:0] EXP_1234 = 64'h12_3456_7808;
    localparam logic [63:0] EXP_81   = 64'h8181;
    localparam int          NB_A     = 40;
    localparam int          NB_S     = 16;
    localparam int          CSL_A    = 164;
    localparam int          CSL_S    = 34;
`else
    localparam logic [63:0] EXP_A53C = 64'hA53C_0FF0;
    localparam logic [63:0] EXP_1122 = 64'h1122_3344;
    localparam logic [63:0] EXP_1234 = 64'h1234_5678;
    localparam logic [63:0] EXP_81   = 64'h81;
    localparam int          NB_A     = 32;
    localparam int          NB_S     = 8;
    localparam int          CSL_A    = 132;
    localparam int          CSL_S    = 18;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_cs(input bit s);
        return s ? ifs.cfg_cs : ifa.cfg_cs;
    endfunction
    function automatic logic sel_sck(input bit s);
        return s ? ifs.cfg_sck : ifa.cfg_sck;
    endfunction
    function automatic logic sel_mosi(input bit s);
        return s ? ifs.cfg_mosi : ifa.cfg_mosi;
    endfunction

    // {cs, sck, mosi, busy, done} of the default instance
    function automatic logic [4:0] pins_a();
        return {ifa.cfg_cs, ifa.cfg_sck, ifa.cfg_mosi, ifa.busy, ifa.done};
    endfunction

    // Called at a negedge sample point; returns at the first cs-high sample after the frame.
    task automatic capture(input bit s, output logic [63:0] bits, output int nb,
                           output int cslow, output int minp, output int maxp);
        int   budget = 0;
        int   t      = 0;
        int   last   = -1;
        logic prev   = 1'b0;
        bits = '0; nb = 0; cslow = 0; minp = 1000; maxp = 0;
        while (sel_cs(s) === 1'b1 && budget < 3000) begin
            @(negedge clk); budget++;
        end
        while (sel_cs(s) === 1'b0 && budget < 3000) begin
            cslow++;
            if (sel_sck(s) === 1'b1 && prev === 1'b0) begin
                bits = {bits[62:0], sel_mosi(s)};
                nb++;
                if (last >= 0) begin
                    if (t - last < minp) minp = t - last;
                    if (t - last > maxp) maxp = t - last;
                end
                last = t;
            end
            prev = sel_sck(s);
            t++;
            @(negedge clk); budget++;
        end
        check("capture_in_budget", 64'(budget < 3000), 64'd1);
    endtask

    task automatic count_edges(input int target, output int edges);
        logic prev = 1'b0;
        int   budget = 0;
        edges = 0;
        while (edges < target && budget < 2000) begin
            @(negedge clk); budget++;
            if (ifa.cfg_sck === 1'b1 && prev === 1'b0) edges++;
            prev = ifa.cfg_sck;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bits;
        int nb, cslow, minp, maxp, edges, gap, dones;

        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.data = '0;
        ifs.start = 1'b0; ifs.abort = 1'b0; ifs.data = '0;

        // reset held for 3 cycles
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pins", 64'(pins_a()), 64'b10000);
        check("reset_small_cs", 64'(ifs.cfg_cs), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("idle_pins", 64'(pins_a()), 64'b10000);

        // asynchronous reset mid-frame at bit 20
        ifa.data = 32'hA53C0FF0; ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        count_edges(20, edges);
        check("t1_edges", 64'(edges), 64'd20);
        #1 reset = 1'b1;
        #1 check("t1_async_reset_pins", 64'(pins_a()), 64'b10000);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // single frame at defaults
        ifa.data = 32'hA53C0FF0; ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        capture(0, bits, nb, cslow, minp, maxp);
        check("t2_bits", bits, EXP_A53C);
        check("t2_nbits", 64'(nb), 64'(NB_A));
        check("t2_cs_low", 64'(cslow), 64'(CSL_A));
        check("t2_sck_period_min", 64'(minp), 64'd4);
        check("t2_sck_period_max", 64'(maxp), 64'd4);
        check("t2_gap1_done_busy", 64'({ifa.done, ifa.busy}), 64'b01);
        @(negedge clk);
        check("t2_gap2_done_busy", 64'({ifa.done, ifa.busy}), 64'b11);
        @(negedge clk);
        check("t2_after_done_busy", 64'({ifa.done, ifa.busy}), 64'b00);

        // start held high, data changed after acceptance
        ifa.data = 32'hA53C0FF0; ifa.start = 1'b1;
        @(negedge clk);
        ifa.data = 32'h11223344;
        capture(0, bits, nb, cslow, minp, maxp);
        check("t3_frame1_bits", bits, EXP_A53C);
        gap = 0; dones = 0;
        while (ifa.cfg_cs === 1'b1 && gap < 20) begin
            gap++;
            if (ifa.done === 1'b1) dones++;
            @(negedge clk);
        end
        ifa.start = 1'b0;
        check("t3_cs_high_gap", 64'(gap), 64'd2);
        check("t3_frame1_done", 64'(dones), 64'd1);
        capture(0, bits, nb, cslow, minp, maxp);
        check("t3_frame2_bits", bits, EXP_1122);
        check("t3_frame2_cs_low", 64'(cslow), 64'(CSL_A));
        repeat (2) @(negedge clk);
        check("t3_idle_busy", 64'(ifa.busy), 64'd0);

        // abort after the 10th rising edge
        ifa.data = 32'hA53C0FF0; ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        count_edges(10, edges);
        check("t4_edges", 64'(edges), 64'd10);
        ifa.abort = 1'b1;
        @(negedge clk); ifa.abort = 1'b0;
        check("t4_abort_pins", 64'(pins_a()), 64'b10010);
        @(negedge clk);
        check("t4_gap2_done_busy", 64'({ifa.done, ifa.busy}), 64'b01);
        @(negedge clk);
        check("t4_busy_dropped", 64'(ifa.busy), 64'd0);
        // abort while idle is ignored; start wins over abort in the same cycle
        ifa.abort = 1'b1;
        @(negedge clk);
        check("t4_idle_abort", 64'(pins_a()), 64'b10000);
        ifa.data = 32'h12345678; ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0; ifa.abort = 1'b0;
        capture(0, bits, nb, cslow, minp, maxp);
        check("t4_refresh_bits", bits, EXP_1234);
        check("t4_refresh_cs_low", 64'(cslow), 64'(CSL_A));
        repeat (3) @(negedge clk);

        // minimal timing instance
        ifs.data = 8'h81; ifs.start = 1'b1;
        @(negedge clk); ifs.start = 1'b0;
        capture(1, bits, nb, cslow, minp, maxp);
        check("t5_bits", bits, EXP_81);
        check("t5_nbits", 64'(nb), 64'(NB_S));
        check("t5_cs_low", 64'(cslow), 64'(CSL_S));
        check("t5_sck_period_min", 64'(minp), 64'd2);
        check("t5_sck_period_max", 64'(maxp), 64'd2);
        check("t5_gap_done", 64'({ifs.done, ifs.busy}), 64'b11);
        @(negedge clk);
        check("t5_idle_busy", 64'(ifs.busy), 64'd0);

        // checksum pattern (plain 32-bit frame when the checksum build is off)
        ifa.data = 32'h12345678; ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        capture(0, bits, nb, cslow, minp, maxp);
        check("t6_bits", bits, EXP_1234);
        check("t6_nbits", 64'(nb), 64'(NB_A));
        check("t6_cs_low", 64'(cslow), 64'(CSL_A));
        dones = 0;
        repeat (4) begin
            if (ifa.done === 1'b1) dones++;
            @(negedge clk);
        end
        check("t6_done_count", 64'(dones), 64'd1);
        check("t6_final_pins", 64'(pins_a()), 64'b10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
